piso_bit_serializer: RTL and testbench

- Parallel-in, serial-out stage that directly feeds the sequence detectors' 1-bit `x` input from word-wide data.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `x`, qualified by `x_valid`.
- Supports gapless back-to-back words, so the detector sees a continuous bit stream.

---
 rtl/seq_pkg.sv | 11 +
 rtl/piso_bit_serializer.sv | 104 ++++++++++
 tb/tb_piso_bit_serializer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the bit-serial front end of the sequence detectors.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int DEFAULT_WORD_WIDTH = 16;

endpackage

// File: rtl/piso_bit_serializer.sv
// Parallel-in serial-out stage: takes a word over valid/ready and emits it
// one bit per clock on x (qualified by x_valid), gapless between words.
module piso_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WORD_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int BL_W = $clog2(WIDTH);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BL_W-1:0]  bits_left_q, bits_left_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;

  logic             accept;
  logic             load_first;
  logic [WIDTH-1:0] load_rest;
  logic             shift_next;
  logic [WIDTH-1:0] shift_rest;

  // Bit order is fixed at elaboration: shreg always keeps the next bit to
  // send at the end that is shifted out first.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign load_first = load_data[WIDTH-1];
      assign load_rest  = {load_data[WIDTH-2:0], 1'b0};
      assign shift_next = shreg_q[WIDTH-1];
      assign shift_rest = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign load_first = load_data[0];
      assign load_rest  = {1'b0, load_data[WIDTH-1:1]};
      assign shift_next = shreg_q[0];
      assign shift_rest = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  // Ready whenever the current bit on x is the last of its word (or nothing
  // is in flight); held low while reset is asserted. Independent of load_valid.
  assign load_ready = reset && ((state_q == IDLE) || (bits_left_q == '0));
  assign accept     = load_valid && load_ready;

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign busy      = (state_q == SHIFT);
  assign word_done = x_valid_q && (bits_left_q == '0);

  // Next-state and next-output decode; a load on the last-bit cycle starts the
  // next word immediately so x_valid never drops between words.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    x_d         = x_q;
    x_valid_d   = x_valid_q;
    if (accept) begin
      state_d     = SHIFT;
      x_d         = load_first;
      x_valid_d   = 1'b1;
      shreg_d     = load_rest;
      bits_left_d = BL_W'(WIDTH - 1);
    end else if (state_q == SHIFT) begin
      if (bits_left_q != '0) begin
        x_d         = shift_next;
        shreg_d     = shift_rest;
        bits_left_d = bits_left_q - 1'b1;
      end else begin
        state_d   = IDLE;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
      end
    end
  end

  // State and datapath registers; async reset discards any partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Self-checking bench: a 16-bit MSB-first and an 8-bit LSB-first instance,
// table-driven single words plus hand-written multi-cycle sequences.
module tb_piso_bit_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        lv16, lv8;
  logic [15:0] ld16;
  logic [7:0]  ld8;
  logic        lr16, x16, xv16, busy16, wd16;
  logic        lr8, x8, xv8, busy8, wd8;

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut16 (
    .clk(clk), .reset(reset), .load_valid(lv16), .load_ready(lr16),
    .load_data(ld16), .x(x16), .x_valid(xv16), .busy(busy16), .word_done(wd16)
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .reset(reset), .load_valid(lv8), .load_ready(lr8),
    .load_data(ld8), .x(x8), .x_valid(xv8), .busy(busy8), .word_done(wd8)
  );

  // Output view of whichever instance is under test
  logic sel;
  logic sx, sxv, sbusy, swd, slr;
  assign sx    = sel ? x8    : x16;
  assign sxv   = sel ? xv8   : xv16;
  assign sbusy = sel ? busy8 : busy16;
  assign swd   = sel ? wd8   : wd16;
  assign slr   = sel ? lr8   : lr16;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full word: seq holds the expected x bits in transmission order,
  // leftmost (bit n-1) first.
  task automatic run_word(input bit d8, input logic [15:0] data,
                          input logic [15:0] seq, input int n, input string nm);
    sel = d8;
    #1;
    chk({nm, " ready_before"}, slr, 1);
    if (d8) begin lv8 = 1'b1; ld8 = data[7:0]; end
    else    begin lv16 = 1'b1; ld16 = data; end
    step();
    lv8 = 1'b0;
    lv16 = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s x[%0d]", nm, i), sx, seq[n-1-i]);
      chk($sformatf("%s x_valid[%0d]", nm, i), sxv, 1);
      chk($sformatf("%s busy[%0d]", nm, i), sbusy, 1);
      chk($sformatf("%s word_done[%0d]", nm, i), swd, (i == n-1));
      chk($sformatf("%s load_ready[%0d]", nm, i), slr, (i == n-1));
      step();
    end
    chk({nm, " x_valid_after"}, sxv, 0);
    chk({nm, " x_after"}, sx, 0);
    chk({nm, " busy_after"}, sbusy, 0);
  endtask

  typedef struct {
    bit          d8;
    logic [15:0] data;
    logic [15:0] seq;
    int          n;
    string       name;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] c3;
    vecs[0] = '{1'b0, 16'b1101011011010110, 16'b1101011011010110, 16, "msb_d6d6"};
    vecs[1] = '{1'b0, 16'h0001, 16'b0000000000000001, 16, "msb_0001"};
    vecs[2] = '{1'b0, 16'hF00F, 16'b1111000000001111, 16, "msb_f00f"};
    vecs[3] = '{1'b1, 16'h00A5, 16'b0000000010100101, 8, "lsb_a5"};
    vecs[4] = '{1'b1, 16'h0001, 16'b0000000010000000, 8, "lsb_01"};
    vecs[5] = '{1'b1, 16'h000E, 16'b0000000001110000, 8, "lsb_0e"};

    reset = 1'b0;
    lv16 = 1'b0; lv8 = 1'b0; ld16 = '0; ld8 = '0; sel = 1'b0;

    // Reset held for two cycles
    step(); step();
    chk("rst x", x16, 0);
    chk("rst x_valid", xv16, 0);
    chk("rst busy", busy16, 0);
    chk("rst word_done", wd16, 0);
    chk("rst load_ready16", lr16, 0);
    chk("rst load_ready8", lr8, 0);
    reset = 1'b1;
    step();
    chk("post_rst load_ready16", lr16, 1);
    chk("post_rst load_ready8", lr8, 1);
    chk("post_rst x_valid", xv16, 0);

    // Table-driven single words on both instances
    for (int v = 0; v < 6; v++)
      run_word(vecs[v].d8, vecs[v].data, vecs[v].seq, vecs[v].n, vecs[v].name);

    // Back-to-back: FFFF then 0000 with load_valid held high
    sel = 1'b0;
    step();
    lv16 = 1'b1; ld16 = 16'hFFFF;
    step();
    ld16 = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b w0 x[%0d]", i), x16, 1);
      chk($sformatf("b2b w0 x_valid[%0d]", i), xv16, 1);
      chk($sformatf("b2b w0 word_done[%0d]", i), wd16, (i == 15));
      chk($sformatf("b2b w0 load_ready[%0d]", i), lr16, (i == 15));
      step();
    end
    lv16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b w1 x[%0d]", i), x16, 0);
      chk($sformatf("b2b w1 x_valid[%0d]", i), xv16, 1);
      chk($sformatf("b2b w1 word_done[%0d]", i), wd16, (i == 15));
      step();
    end
    chk("b2b x_valid_end", xv16, 0);
    chk("b2b busy_end", busy16, 0);

    // Load attempted mid-word (bits_left == 7) is ignored
    step();
    c3 = 16'hC3C3;
    lv16 = 1'b1; ld16 = c3;
    step();
    lv16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        chk("mid ready_low", lr16, 0);
        lv16 = 1'b1; ld16 = 16'hAAAA;
      end
      if (i == 9) lv16 = 1'b0;
      chk($sformatf("mid x[%0d]", i), x16, c3[15-i]);
      chk($sformatf("mid x_valid[%0d]", i), xv16, 1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid idle x_valid[%0d]", i), xv16, 0);
      step();
    end

    // Reset asserted mid-word after five bits of F0F0
    lv16 = 1'b1; ld16 = 16'hF0F0;
    step();
    lv16 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rmid x[%0d]", i), x16, (i < 4));
      step();
    end
    chk("rmid busy_before", busy16, 1);
    reset = 1'b0;
    #2;
    chk("rmid async x", x16, 0);
    chk("rmid async x_valid", xv16, 0);
    chk("rmid async busy", busy16, 0);
    chk("rmid async word_done", wd16, 0);
    chk("rmid async load_ready", lr16, 0);
    step(); step();
    reset = 1'b1;
    step();
    chk("rmid no_resume x_valid", xv16, 0);
    chk("rmid no_resume busy", busy16, 0);
    run_word(1'b0, 16'h8001, 16'b1000000000000001, 16, "rmid_8001");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
